// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg
//   Shared sizing constants for the reorder buffer.
//   ROB_SIZE entries are addressed by ROB_W-bit tags. Tag ZERO_ROB means
//   "no tag" and is never allocated, so tags 1..ROB_SIZE-1 are usable.
package reorder_buffer_pkg;

  localparam int ROB_SIZE = 16;
  localparam int ROB_W    = 4;
  localparam int REG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;

  localparam logic [ROB_W-1:0] ZERO_ROB  = '0;
  localparam logic [ROB_W-1:0] FIRST_TAG = ROB_W'(1);
  // Highest occupancy; one slot is lost to the reserved tag.
  localparam logic [ROB_W-1:0] MAX_COUNT = ROB_W'(ROB_SIZE - 1);

endpackage

// File: rtl/reorder_buffer.sv
// reorder_buffer
//   In-order retirement stage. The decoder allocates one entry per issued
//   instruction, results arrive out of order on the CDB, and the head entry
//   retires once ready. A mispredicted branch at the head flushes everything.
// Ports
//   clk, rst             clock; synchronous active-high reset (beats ena)
//   ena                  global enable, 0 freezes all state
//   in_alloc_*           allocation request: rd, is_branch, pred_taken
//   out_alloc_tag        tag the next allocation gets (tail), comb
//   out_full             no free entry, comb
//   in_cdb_*             result broadcast: tag, value, taken, target
//   in_query_tag1/2      operand tags; out_query_ready/value1/2 comb answers
//   out_commit_reg/tag/value   retiring entry, registered one-cycle pulse
//   out_flush, out_jump_pc     mispredict redirect, registered pulse
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              in_alloc_ena,
  input  logic [REG_W-1:0]  in_alloc_rd,
  input  logic              in_alloc_is_branch,
  input  logic              in_alloc_pred_taken,
  output logic [ROB_W-1:0]  out_alloc_tag,
  output logic              out_full,
  input  logic              in_cdb_ena,
  input  logic [ROB_W-1:0]  in_cdb_tag,
  input  logic [DATA_W-1:0] in_cdb_value,
  input  logic              in_cdb_taken,
  input  logic [ADDR_W-1:0] in_cdb_target,
  input  logic [ROB_W-1:0]  in_query_tag1,
  input  logic [ROB_W-1:0]  in_query_tag2,
  output logic              out_query_ready1,
  output logic              out_query_ready2,
  output logic [DATA_W-1:0] out_query_value1,
  output logic [DATA_W-1:0] out_query_value2,
  output logic [REG_W-1:0]  out_commit_reg,
  output logic [ROB_W-1:0]  out_commit_tag,
  output logic [DATA_W-1:0] out_commit_value,
  output logic              out_flush,
  output logic [ADDR_W-1:0] out_jump_pc
);

  // Pointers skip the reserved tag 0.
  function automatic logic [ROB_W-1:0] next_tag(input logic [ROB_W-1:0] tag);
    return (tag == MAX_COUNT) ? FIRST_TAG : tag + ROB_W'(1);
  endfunction

  logic [ROB_W-1:0]    head_reg, tail_reg, count_reg;
  logic [ROB_SIZE-1:0] valid_reg, ready_reg;

  logic [REG_W-1:0]    rd_mem     [ROB_SIZE];
  logic                branch_mem [ROB_SIZE];
  logic                pred_mem   [ROB_SIZE];
  logic                taken_mem  [ROB_SIZE];
  logic [DATA_W-1:0]   value_mem  [ROB_SIZE];
  logic [ADDR_W-1:0]   target_mem [ROB_SIZE];

  logic alloc_fire, commit_fire, cdb_hit, mispredict;

  assign out_alloc_tag = tail_reg;
  assign out_full      = (count_reg == MAX_COUNT);

  assign alloc_fire  = in_alloc_ena && !out_full;
  assign commit_fire = (count_reg != '0) && valid_reg[head_reg] && ready_reg[head_reg];
  assign cdb_hit     = in_cdb_ena && (in_cdb_tag != ZERO_ROB) && valid_reg[in_cdb_tag];
  assign mispredict  = commit_fire && branch_mem[head_reg] &&
                       (taken_mem[head_reg] != pred_mem[head_reg]);

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg         <= FIRST_TAG;
      tail_reg         <= FIRST_TAG;
      count_reg        <= '0;
      valid_reg        <= '0;
      ready_reg        <= '0;
      out_commit_reg   <= '0;
      out_commit_tag   <= ZERO_ROB;
      out_commit_value <= '0;
      out_flush        <= 1'b0;
      out_jump_pc      <= '0;
    end else begin
      // Outputs are pulses: idle unless something retires this edge.
      out_commit_reg   <= '0;
      out_commit_tag   <= ZERO_ROB;
      out_commit_value <= '0;
      out_flush        <= 1'b0;
      out_jump_pc      <= '0;

      if (ena) begin
        // CDB write precedes the commit clear so a late broadcast to the
        // retiring head cannot resurrect its ready bit.
        if (cdb_hit) begin
          ready_reg[in_cdb_tag]  <= 1'b1;
          value_mem[in_cdb_tag]  <= in_cdb_value;
          taken_mem[in_cdb_tag]  <= in_cdb_taken;
          target_mem[in_cdb_tag] <= in_cdb_target;
        end

        if (commit_fire) begin
          out_commit_reg      <= rd_mem[head_reg];
          out_commit_tag      <= head_reg;
          out_commit_value    <= value_mem[head_reg];
          valid_reg[head_reg] <= 1'b0;
          ready_reg[head_reg] <= 1'b0;
          head_reg            <= next_tag(head_reg);
        end

        // Tail is never the head here: alloc is blocked when full.
        if (alloc_fire) begin
          valid_reg[tail_reg]  <= 1'b1;
          ready_reg[tail_reg]  <= 1'b0;
          rd_mem[tail_reg]     <= in_alloc_rd;
          branch_mem[tail_reg] <= in_alloc_is_branch;
          pred_mem[tail_reg]   <= in_alloc_pred_taken;
          tail_reg             <= next_tag(tail_reg);
        end

        case ({alloc_fire, commit_fire})
          2'b10:   count_reg <= count_reg + ROB_W'(1);
          2'b01:   count_reg <= count_reg - ROB_W'(1);
          default: count_reg <= count_reg;
        endcase

        // Squash overrides everything above, including a same-cycle alloc.
        if (mispredict) begin
          out_flush   <= 1'b1;
          out_jump_pc <= target_mem[head_reg];
          valid_reg   <= '0;
          ready_reg   <= '0;
          head_reg    <= FIRST_TAG;
          tail_reg    <= FIRST_TAG;
          count_reg   <= '0;
        end
      end
    end
  end

  // Operand queries: stored result, or same-cycle CDB bypass.
  logic [1:0][ROB_W-1:0]  q_tag;
  logic [1:0]             q_ready;
  logic [1:0][DATA_W-1:0] q_value;

  assign q_tag = {in_query_tag2, in_query_tag1};

  for (genvar gi = 0; gi < 2; gi++) begin : g_query
    logic live, stored_hit, bypass_hit;
    assign live       = (q_tag[gi] != ZERO_ROB) && valid_reg[q_tag[gi]];
    assign stored_hit = live && ready_reg[q_tag[gi]];
    assign bypass_hit = live && in_cdb_ena && (in_cdb_tag == q_tag[gi]);
    assign q_ready[gi] = stored_hit || bypass_hit;
    assign q_value[gi] = bypass_hit ? in_cdb_value :
                         stored_hit ? value_mem[q_tag[gi]] : '0;
  end

  assign out_query_ready1 = q_ready[0];
  assign out_query_ready2 = q_ready[1];
  assign out_query_value1 = q_value[0];
  assign out_query_value2 = q_value[1];

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer
//   Self-checking bench for reorder_buffer. Expected commits are queued as
//   results are broadcast; a monitor pops and compares each retirement.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic              clk = 1'b0;
  logic              rst, ena;
  logic              in_alloc_ena, in_alloc_is_branch, in_alloc_pred_taken;
  logic [REG_W-1:0]  in_alloc_rd;
  logic [ROB_W-1:0]  out_alloc_tag;
  logic              out_full;
  logic              in_cdb_ena, in_cdb_taken;
  logic [ROB_W-1:0]  in_cdb_tag;
  logic [DATA_W-1:0] in_cdb_value;
  logic [ADDR_W-1:0] in_cdb_target;
  logic [ROB_W-1:0]  in_query_tag1, in_query_tag2;
  logic              out_query_ready1, out_query_ready2;
  logic [DATA_W-1:0] out_query_value1, out_query_value2;
  logic [REG_W-1:0]  out_commit_reg;
  logic [ROB_W-1:0]  out_commit_tag;
  logic [DATA_W-1:0] out_commit_value;
  logic              out_flush;
  logic [ADDR_W-1:0] out_jump_pc;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .ena(ena),
    .in_alloc_ena(in_alloc_ena), .in_alloc_rd(in_alloc_rd),
    .in_alloc_is_branch(in_alloc_is_branch), .in_alloc_pred_taken(in_alloc_pred_taken),
    .out_alloc_tag(out_alloc_tag), .out_full(out_full),
    .in_cdb_ena(in_cdb_ena), .in_cdb_tag(in_cdb_tag), .in_cdb_value(in_cdb_value),
    .in_cdb_taken(in_cdb_taken), .in_cdb_target(in_cdb_target),
    .in_query_tag1(in_query_tag1), .in_query_tag2(in_query_tag2),
    .out_query_ready1(out_query_ready1), .out_query_ready2(out_query_ready2),
    .out_query_value1(out_query_value1), .out_query_value2(out_query_value2),
    .out_commit_reg(out_commit_reg), .out_commit_tag(out_commit_tag),
    .out_commit_value(out_commit_value),
    .out_flush(out_flush), .out_jump_pc(out_jump_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [REG_W-1:0]  rd;
    logic [ROB_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } commit_t;

  commit_t exp_q[$];
  commit_t mon_e;
  int n_vectors     = 0;
  int n_miscompares = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_alloc_ena = 0; in_alloc_rd = 0; in_alloc_is_branch = 0; in_alloc_pred_taken = 0;
    in_cdb_ena = 0; in_cdb_tag = 0; in_cdb_value = 0; in_cdb_taken = 0; in_cdb_target = 0;
    in_query_tag1 = 0; in_query_tag2 = 0;
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0;
  endtask

  task automatic alloc(input logic [REG_W-1:0] rd, input logic br, input logic pred);
    in_alloc_ena = 1; in_alloc_rd = rd; in_alloc_is_branch = br; in_alloc_pred_taken = pred;
    step();
    in_alloc_ena = 0; in_alloc_is_branch = 0; in_alloc_pred_taken = 0;
  endtask

  task automatic cdb(input logic [ROB_W-1:0] tag, input logic [DATA_W-1:0] val,
                     input logic taken, input logic [ADDR_W-1:0] target);
    in_cdb_ena = 1; in_cdb_tag = tag; in_cdb_value = val;
    in_cdb_taken = taken; in_cdb_target = target;
  endtask

  // Scoreboard monitor: every retirement must match the oldest expectation.
  always @(posedge clk) begin
    #2;
    if (out_commit_tag != ZERO_ROB) begin
      if (exp_q.size() == 0) begin
        check_value("unexpected_commit_tag", 32'(out_commit_tag), 32'(ZERO_ROB));
      end else begin
        mon_e = exp_q.pop_front();
        check_value("commit_tag",   32'(out_commit_tag), 32'(mon_e.tag));
        check_value("commit_reg",   32'(out_commit_reg), 32'(mon_e.rd));
        check_value("commit_value", out_commit_value,    mon_e.value);
        $display("commit tag=%0d reg=%0d value=0x%0h", out_commit_tag, out_commit_reg, out_commit_value);
      end
    end
  end

  initial begin
    rst = 1; ena = 1;
    idle_inputs();
    step(); step();
    rst = 0;
    #1;
    check_value("rst_alloc_tag", 32'(out_alloc_tag), 1);
    check_value("rst_full", 32'(out_full), 0);
    check_value("rst_commit_tag", 32'(out_commit_tag), 0);
    check_value("rst_commit_reg", 32'(out_commit_reg), 0);
    check_value("rst_commit_value", out_commit_value, 0);
    check_value("rst_flush", 32'(out_flush), 0);
    check_value("rst_jump_pc", out_jump_pc, 0);

    // 1: three allocations, nothing retires without results.
    alloc(1, 0, 0); alloc(2, 0, 0); alloc(3, 0, 0);
    check_value("t1_alloc_tag", 32'(out_alloc_tag), 4);
    step(); step();
    check_value("t1_no_commit", 32'(out_commit_tag), 0);

    // 2: out-of-order results, in-order consecutive retirement.
    exp_q.push_back('{rd: 1, tag: 1, value: 32'h11});
    exp_q.push_back('{rd: 2, tag: 2, value: 32'h22});
    exp_q.push_back('{rd: 3, tag: 3, value: 32'h33});
    cdb(3, 32'h33, 0, 0); step();
    cdb(1, 32'h11, 0, 0); step();
    cdb(2, 32'h22, 0, 0); step();
    in_cdb_ena = 0;
    check_value("t2_commit1", 32'(out_commit_tag), 1);
    step();
    check_value("t2_commit2", 32'(out_commit_tag), 2);
    step();
    check_value("t2_commit3", 32'(out_commit_tag), 3);
    step();
    check_value("t2_idle", 32'(out_commit_tag), 0);
    check_value("t2_drained", exp_q.size(), 0);

    // 3: fill, overflow attempt, retire head, wrap allocation.
    do_reset();
    for (int i = 1; i <= 15; i++) alloc(5'(i), 0, 0);
    in_alloc_ena = 1; in_alloc_rd = 31;
    #1;
    check_value("t3_full", 32'(out_full), 1);
    check_value("t3_full_tag", 32'(out_alloc_tag), 1);
    step();
    in_alloc_ena = 0;
    check_value("t3_overflow_tag", 32'(out_alloc_tag), 1);
    check_value("t3_still_full", 32'(out_full), 1);
    exp_q.push_back('{rd: 1, tag: 1, value: 32'hA1});
    cdb(1, 32'hA1, 0, 0); step();
    in_cdb_ena = 0; step();
    check_value("t3_commit_tag", 32'(out_commit_tag), 1);
    check_value("t3_not_full", 32'(out_full), 0);
    check_value("t3_wrap_tag", 32'(out_alloc_tag), 1);
    alloc(20, 0, 0);
    check_value("t3_after_wrap_tag", 32'(out_alloc_tag), 2);
    check_value("t3_full_again", 32'(out_full), 1);

    // 4: mispredicted branch at head flushes younger work.
    do_reset();
    alloc(0, 1, 0); alloc(7, 0, 0); alloc(8, 0, 0);
    cdb(2, 32'h77, 0, 0); step();
    exp_q.push_back('{rd: 0, tag: 1, value: 32'h0});
    cdb(1, 32'h0, 1, 32'h100); step();
    in_cdb_ena = 0;
    in_alloc_ena = 1; in_alloc_rd = 9;
    #1;
    check_value("t4_pre_flush_tag", 32'(out_alloc_tag), 4);
    step();
    in_alloc_ena = 0;
    check_value("t4_flush", 32'(out_flush), 1);
    check_value("t4_jump_pc", out_jump_pc, 32'h100);
    check_value("t4_branch_commit", 32'(out_commit_tag), 1);
    check_value("t4_flush_tag", 32'(out_alloc_tag), 1);
    check_value("t4_flush_full", 32'(out_full), 0);
    step();
    check_value("t4_flush_pulse", 32'(out_flush), 0);
    check_value("t4_jump_idle", out_jump_pc, 0);
    step(); step();
    check_value("t4_no_young_commit", 32'(out_commit_tag), 0);

    // 5: query with same-cycle CDB bypass, reserved and unfinished tags.
    do_reset();
    for (int i = 1; i <= 5; i++) alloc(5'(i), 0, 0);
    in_query_tag1 = 5; in_query_tag2 = 4;
    #1;
    check_value("t5_q5_not_ready", 32'(out_query_ready1), 0);
    check_value("t5_q4_value0", out_query_value2, 0);
    cdb(5, 32'hDEADBEEF, 0, 0);
    in_query_tag2 = 0;
    #1;
    check_value("t5_bypass_ready", 32'(out_query_ready1), 1);
    check_value("t5_bypass_value", out_query_value1, 32'hDEADBEEF);
    check_value("t5_q0_ready", 32'(out_query_ready2), 0);
    check_value("t5_q0_value", out_query_value2, 0);
    step();
    in_cdb_ena = 0; in_query_tag2 = 6;
    #1;
    check_value("t5_stored_value", out_query_value1, 32'hDEADBEEF);
    check_value("t5_invalid_ready", 32'(out_query_ready2), 0);
    in_query_tag1 = 0; in_query_tag2 = 0;

    // 6: reset with live entries, then enable gating.
    do_reset();
    for (int i = 1; i <= 7; i++) alloc(5'(i), 0, 0);
    check_value("t6_live_tag", 32'(out_alloc_tag), 8);
    rst = 1; in_alloc_ena = 1; in_alloc_rd = 3;
    step();
    rst = 0; in_alloc_ena = 0;
    check_value("t6_rst_tag", 32'(out_alloc_tag), 1);
    check_value("t6_rst_full", 32'(out_full), 0);
    check_value("t6_rst_commit", 32'(out_commit_tag), 0);
    check_value("t6_rst_flush", 32'(out_flush), 0);
    ena = 0;
    alloc(4, 0, 0);
    check_value("t6_ena_freeze", 32'(out_alloc_tag), 1);
    ena = 1;
    alloc(4, 0, 0);
    check_value("t6_ena_alloc", 32'(out_alloc_tag), 2);
    step(); step();

    check_value("final_scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
